// File: rtl/led_matrix_pkg.sv
// Shared state encoding and memory-port widths for the LED matrix frame-buffer path.
// The device controller and the scan-out fetcher use the same widths.
package led_matrix_pkg;

    localparam int MEM_ADDRESS_WIDTH = 25;
    localparam int MEM_DATA_WIDTH    = 16;
    localparam int RD_LEN_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_ISSUE = 2'd2,
        READ_WAIT  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the frame-buffer memory command port between host writes and scan-out
// read bursts. Reads have priority, and a read streak limit keeps host writes moving.
module mem_port_arbiter
    import led_matrix_pkg::*;
#(
    parameter int ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int LEN_WIDTH     = RD_LEN_WIDTH,
    parameter int WR_BURST_MAX  = 16,
    parameter int RD_STREAK_MAX = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    input  logic                     rd_req,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    input  logic [LEN_WIDTH-1:0]     rd_len,
    output logic                     rd_ack,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_data_valid,
    output logic                     rd_done,
    output logic [ADDRESS_WIDTH-1:0] address_mem,
    output logic                     wr_mem,
    output logic [DATA_WIDTH-1:0]    data_out_mem,
    output logic                     data_out_ready_mem,
    input  logic                     fifo_full_mem,
    input  logic [DATA_WIDTH-1:0]    data_in_mem,
    input  logic                     data_in_ready_mem,
    output logic                     rd_overflow
);

    localparam int WC_W = $clog2(WR_BURST_MAX + 1);
    localparam int RS_W = $clog2(RD_STREAK_MAX + 1);
    localparam logic [WC_W-1:0] WR_MAX = WC_W'(WR_BURST_MAX);
    localparam logic [RS_W-1:0] RS_MAX = RS_W'(RD_STREAK_MAX);

    arb_state_t               state;
    logic [WC_W-1:0]          wr_count;
    logic [RS_W-1:0]          rd_streak;
    logic [ADDRESS_WIDTH-1:0] rd_base;
    logic [LEN_WIDTH-1:0]     rd_len_q;
    logic [LEN_WIDTH-1:0]     issued;
    logic [LEN_WIDTH-1:0]     returned;
    logic                     read_active;
    logic                     ret_accept;

    function automatic logic [RS_W-1:0] sat_inc(input logic [RS_W-1:0] v);
        return (v == RS_MAX) ? v : v + RS_W'(1);
    endfunction

    assign wr_ready    = (state == WRITE) && !fifo_full_mem && (wr_count < WR_MAX);
    assign read_active = (state == READ_ISSUE) || (state == READ_WAIT);
    // Returns outside a burst, or beyond its length, are dropped and flagged.
    assign ret_accept  = data_in_ready_mem && read_active && (returned < rd_len_q);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            wr_count           <= '0;
            rd_streak          <= '0;
            rd_base            <= '0;
            rd_len_q           <= '0;
            issued             <= '0;
            returned           <= '0;
            address_mem        <= '0;
            data_out_mem       <= '0;
            rd_data            <= '0;
            wr_mem             <= 1'b0;
            data_out_ready_mem <= 1'b0;
            rd_ack             <= 1'b0;
            rd_done            <= 1'b0;
            rd_data_valid      <= 1'b0;
            rd_overflow        <= 1'b0;
        end else begin
            data_out_ready_mem <= 1'b0;
            rd_ack             <= 1'b0;
            rd_done            <= 1'b0;
            rd_data_valid      <= 1'b0;
            if (data_in_ready_mem && !ret_accept) begin
                rd_overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rd_req && ((rd_streak < RS_MAX) || !wr_valid)) begin
                        rd_base   <= rd_address;
                        rd_len_q  <= rd_len;
                        issued    <= '0;
                        returned  <= '0;
                        rd_ack    <= 1'b1;
                        rd_streak <= sat_inc(rd_streak);
                        state     <= READ_ISSUE;
                    end else if (wr_valid) begin
                        rd_streak <= '0;
                        wr_count  <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (!wr_valid) begin
                        state <= IDLE;
                    end else if (wr_ready) begin
                        address_mem        <= wr_address;
                        data_out_mem       <= wr_data;
                        wr_mem             <= 1'b1;
                        data_out_ready_mem <= 1'b1;
                        wr_count           <= wr_count + WC_W'(1);
                        if (wr_count + WC_W'(1) == WR_MAX) begin
                            state <= IDLE;
                        end
                    end
                end
                READ_ISSUE: begin
                    if (rd_len_q == '0) begin
                        rd_done <= 1'b1;
                        state   <= IDLE;
                    end else if (!fifo_full_mem) begin
                        address_mem        <= rd_base + ADDRESS_WIDTH'(issued);
                        wr_mem             <= 1'b0;
                        data_out_ready_mem <= 1'b1;
                        issued             <= issued + LEN_WIDTH'(1);
                        if (issued + LEN_WIDTH'(1) == rd_len_q) begin
                            state <= READ_WAIT;
                        end
                    end
                end
                default: ;
            endcase

            // Placed after the case so completion of the burst overrides the issue transition.
            if (ret_accept) begin
                rd_data       <= data_in_mem;
                rd_data_valid <= 1'b1;
                returned      <= returned + LEN_WIDTH'(1);
                if (returned + LEN_WIDTH'(1) == rd_len_q) begin
                    rd_done <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: write/read requester models, a memory
// model answering read commands two cycles later, and per-scenario tasks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic [LW-1:0] rd_len = '0;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_done;
    logic [AW-1:0] address_mem;
    logic          wr_mem;
    logic [DW-1:0] data_out_mem;
    logic          data_out_ready_mem;
    logic          fifo_full_mem = 1'b0;
    logic [DW-1:0] data_in_mem = '0;
    logic          data_in_ready_mem = 1'b0;
    logic          rd_overflow;

    mem_port_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .WR_BURST_MAX(16), .RD_STREAK_MAX(4)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_address(rd_address), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
        .address_mem(address_mem), .wr_mem(wr_mem), .data_out_mem(data_out_mem),
        .data_out_ready_mem(data_out_ready_mem), .fifo_full_mem(fifo_full_mem),
        .data_in_mem(data_in_mem), .data_in_ready_mem(data_in_ready_mem),
        .rd_overflow(rd_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic wr; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
    typedef struct { logic [DW-1:0] d; logic done; } rdw_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wword_t;
    typedef struct { logic [AW-1:0] a; logic [LW-1:0] n; } rreq_t;
    typedef struct { int due; logic [DW-1:0] d; } ret_t;

    cmd_t   exp_cmd[$];
    rdw_t   exp_rd[$];
    wword_t wq[$];
    rreq_t  rq[$];
    ret_t   mem_q[$];
    int     cmd_cyc[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_ack = 0;
    int   n_rdv = 0;
    logic mem_en = 1'b1;
    logic inj = 1'b0;
    logic hs = 1'b0;

    logic [AW+2*DW+6:0] all_outs;
    assign all_outs = {address_mem, data_out_mem, rd_data, wr_mem, data_out_ready_mem,
                       rd_ack, rd_done, rd_data_valid, rd_overflow, wr_ready};

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // Monitor/scoreboard and memory model, all on the falling edge.
    initial begin
        cmd_t e;
        rdw_t r;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (mem_en && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                data_in_ready_mem = 1'b1;
                data_in_mem       = mem_q[0].d;
                void'(mem_q.pop_front());
            end else begin
                data_in_ready_mem = inj;
                data_in_mem       = 16'hDEAD;
            end
            if (!reset) begin
                if (rd_ack) n_ack++;
                if (data_out_ready_mem) begin
                    cmd_cyc.push_back(cyc);
                    if (!wr_mem && mem_en) mem_q.push_back('{cyc + 2, mem_word(address_mem)});
                    n_cmp++;
                    if (exp_cmd.size() == 0) begin
                        $display("FAIL cmd_unexpected: got wr=%0d addr=%h data=%h, want no command",
                                 wr_mem, address_mem, data_out_mem);
                        n_bad++;
                    end else begin
                        e = exp_cmd.pop_front();
                        if (wr_mem !== e.wr || address_mem !== e.a || (e.wr && data_out_mem !== e.d)) begin
                            $display("FAIL cmd: got wr=%0d addr=%h data=%h, want wr=%0d addr=%h data=%h",
                                     wr_mem, address_mem, data_out_mem, e.wr, e.a, e.d);
                            n_bad++;
                        end
                    end
                end
                if (rd_data_valid) begin
                    n_rdv++;
                    n_cmp++;
                    if (exp_rd.size() == 0) begin
                        $display("FAIL rd_unexpected: got data=%h done=%0d, want no read data", rd_data, rd_done);
                        n_bad++;
                    end else begin
                        r = exp_rd.pop_front();
                        if (rd_data !== r.d || rd_done !== r.done) begin
                            $display("FAIL rd_data: got data=%h done=%0d, want data=%h done=%0d",
                                     rd_data, rd_done, r.d, r.done);
                            n_bad++;
                        end
                    end
                end
            end
        end
    end

    // Host write stream: holds wr_valid while words are queued.
    initial forever begin
        @(negedge clk_sys);
        hs = wr_valid && wr_ready;
        @(posedge clk_sys);
        #1;
        if (hs && wq.size() != 0) void'(wq.pop_front());
        wr_valid = (wq.size() != 0);
        if (wr_valid) begin
            wr_address = wq[0].a;
            wr_data    = wq[0].d;
        end
    end

    // Scan-out requester: holds rd_req until rd_ack, then presents the next request.
    initial forever begin
        @(posedge clk_sys);
        #1;
        if (rd_ack && rq.size() != 0) void'(rq.pop_front());
        rd_req = (rq.size() != 0);
        if (rd_req) begin
            rd_address = rq[0].a;
            rd_len     = rq[0].n;
        end
    end

    task automatic drain(output bit to);
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_rd.size() != 0 || wq.size() != 0 || rq.size() != 0) && t < 600) begin
            @(posedge clk_sys);
            #1;
            t++;
        end
        to = (t >= 600);
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        n_cmp++;
        if (all_outs !== '0) begin
            $display("FAIL reset_outputs: got %h, want 0", all_outs);
            n_bad++;
        end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_write_only();
        bit to;
        @(negedge clk_sys);
        cmd_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{AW'(32'h100 + i), DW'(32'hA1 + i)});
            exp_cmd.push_back('{1'b1, AW'(32'h100 + i), DW'(32'hA1 + i)});
        end
        drain(to);
        n_cmp++;
        if (to) begin $display("FAIL wr_only_timeout: got pending, want drained"); n_bad++; end
        n_cmp++;
        if (cmd_cyc.size() != 3) begin
            $display("FAIL wr_only_count: got %0d, want 3", cmd_cyc.size());
            n_bad++;
        end else begin
            n_cmp++;
            if (cmd_cyc[2] - cmd_cyc[0] != 2) begin
                $display("FAIL wr_only_consecutive: got span %0d, want 2", cmd_cyc[2] - cmd_cyc[0]);
                n_bad++;
            end
        end
        n_cmp++;
        if ({wr_ready, data_out_ready_mem} !== 2'b00) begin
            $display("FAIL wr_only_idle: got ready/strobe %b, want 00", {wr_ready, data_out_ready_mem});
            n_bad++;
        end
    endtask

    task automatic test_read_burst();
        bit to;
        int a0 = n_ack;
        int v0 = n_rdv;
        @(negedge clk_sys);
        rq.push_back('{AW'(32'h2000), LW'(4)});
        for (int i = 0; i < 4; i++) begin
            exp_cmd.push_back('{1'b0, AW'(32'h2000 + i), '0});
            exp_rd.push_back('{mem_word(AW'(32'h2000 + i)), (i == 3)});
        end
        drain(to);
        n_cmp++;
        if (to) begin $display("FAIL rd_burst_timeout: got pending, want drained"); n_bad++; end
        n_cmp++;
        if (n_ack - a0 != 1) begin
            $display("FAIL rd_burst_ack: got %0d acks, want 1", n_ack - a0);
            n_bad++;
        end
        n_cmp++;
        if (n_rdv - v0 != 4) begin
            $display("FAIL rd_burst_valid: got %0d, want 4", n_rdv - v0);
            n_bad++;
        end
        n_cmp++;
        if (rd_overflow !== 1'b0) begin
            $display("FAIL rd_burst_overflow: got %b, want 0", rd_overflow);
            n_bad++;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int t = 0;
        @(negedge clk_sys);
        cmd_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            wq.push_back('{AW'(32'h600 + i), DW'(32'h7700 + i)});
            exp_cmd.push_back('{1'b1, AW'(32'h600 + i), DW'(32'h7700 + i)});
        end
        while (cmd_cyc.size() < 3 && t < 100) begin
            @(posedge clk_sys);
            #1;
            t++;
        end
        n_cmp++;
        if (t >= 100) begin $display("FAIL bp_start_timeout: got %0d cmds, want 3", cmd_cyc.size()); n_bad++; end
        fifo_full_mem = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            n_cmp++;
            if (wr_ready !== 1'b0) begin
                $display("FAIL bp_wr_ready: got %b, want 0 (cycle %0d)", wr_ready, k);
                n_bad++;
            end
            if (k > 0) begin
                n_cmp++;
                if (data_out_ready_mem !== 1'b0) begin
                    $display("FAIL bp_strobe: got %b, want 0 (cycle %0d)", data_out_ready_mem, k);
                    n_bad++;
                end
            end
        end
        @(posedge clk_sys);
        #1;
        fifo_full_mem = 1'b0;
        drain(to);
        n_cmp++;
        if (to) begin $display("FAIL bp_timeout: got pending, want drained"); n_bad++; end
        n_cmp++;
        if (cmd_cyc.size() != 8) begin
            $display("FAIL bp_count: got %0d, want 8", cmd_cyc.size());
            n_bad++;
        end
    endtask

    task automatic test_starvation();
        bit to;
        int a0 = n_ack;
        @(negedge clk_sys);
        for (int i = 0; i < 6; i++) begin
            rq.push_back('{AW'(32'h300 + i), LW'(1)});
            exp_rd.push_back('{mem_word(AW'(32'h300 + i)), 1'b1});
        end
        for (int j = 0; j < 20; j++) wq.push_back('{AW'(32'h400 + j), DW'(32'hB000 + j)});
        for (int i = 0; i < 4; i++) exp_cmd.push_back('{1'b0, AW'(32'h300 + i), '0});
        for (int j = 0; j < 16; j++) exp_cmd.push_back('{1'b1, AW'(32'h400 + j), DW'(32'hB000 + j)});
        for (int i = 4; i < 6; i++) exp_cmd.push_back('{1'b0, AW'(32'h300 + i), '0});
        for (int j = 16; j < 20; j++) exp_cmd.push_back('{1'b1, AW'(32'h400 + j), DW'(32'hB000 + j)});
        drain(to);
        n_cmp++;
        if (to) begin $display("FAIL starve_timeout: got pending, want drained"); n_bad++; end
        n_cmp++;
        if (n_ack - a0 != 6) begin
            $display("FAIL starve_acks: got %0d, want 6", n_ack - a0);
            n_bad++;
        end
    endtask

    task automatic test_boundaries();
        bit to;
        int t = 0;
        int c0;
        int v0;
        @(negedge clk_sys);
        rq.push_back('{AW'(32'h1FFFFFF), LW'(2)});
        exp_cmd.push_back('{1'b0, AW'(32'h1FFFFFF), '0});
        exp_cmd.push_back('{1'b0, AW'(32'h0), '0});
        exp_rd.push_back('{mem_word(AW'(32'h1FFFFFF)), 1'b0});
        exp_rd.push_back('{mem_word(AW'(32'h0)), 1'b1});
        drain(to);
        n_cmp++;
        if (to) begin $display("FAIL wrap_timeout: got pending, want drained"); n_bad++; end

        c0 = cmd_cyc.size();
        v0 = n_rdv;
        @(negedge clk_sys);
        rq.push_back('{AW'(32'h123), LW'(0)});
        while (rd_ack !== 1'b1 && t < 20) begin
            @(posedge clk_sys);
            #1;
            t++;
        end
        n_cmp++;
        if (t >= 20) begin $display("FAIL len0_ack: got no rd_ack, want 1"); n_bad++; end
        @(posedge clk_sys);
        #1;
        n_cmp++;
        if ({rd_done, rd_data_valid} !== 2'b10) begin
            $display("FAIL len0_done: got done/valid %b, want 10", {rd_done, rd_data_valid});
            n_bad++;
        end
        drain(to);
        n_cmp++;
        if (cmd_cyc.size() != c0 || n_rdv != v0) begin
            $display("FAIL len0_quiet: got %0d cmds %0d data, want 0 and 0", cmd_cyc.size() - c0, n_rdv - v0);
            n_bad++;
        end
    endtask

    task automatic test_reset_overflow();
        bit to;
        int v0;
        mem_en = 1'b0;
        @(negedge clk_sys);
        rq.push_back('{AW'(32'h500), LW'(4)});
        for (int i = 0; i < 4; i++) exp_cmd.push_back('{1'b0, AW'(32'h500 + i), '0});
        drain(to);
        n_cmp++;
        if (to) begin $display("FAIL rst_issue_timeout: got pending, want drained"); n_bad++; end
        v0 = n_rdv;
        reset = 1'b1;
        @(negedge clk_sys);
        n_cmp++;
        if (all_outs !== '0) begin
            $display("FAIL rst_mid_outputs: got %h, want 0", all_outs);
            n_bad++;
        end
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (all_outs !== '0) begin
            $display("FAIL rst_release_outputs: got %h, want 0", all_outs);
            n_bad++;
        end
        @(posedge clk_sys);
        #1;
        inj = 1'b1;
        @(posedge clk_sys);
        #1;
        inj = 1'b0;
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if (rd_overflow !== 1'b1) begin
            $display("FAIL rst_overflow: got %b, want 1", rd_overflow);
            n_bad++;
        end
        n_cmp++;
        if (n_rdv != v0 || rd_data_valid !== 1'b0) begin
            $display("FAIL rst_no_forward: got %0d data, want 0", n_rdv - v0);
            n_bad++;
        end
        mem_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_read_burst();
        test_backpressure();
        test_starvation();
        test_boundaries();
        test_reset_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
